// File: rtl/axioma_uart_io_bridge_pkg.sv
// Shared constants for the UART to I/O bus debug bridge:
// command opcodes, reply codes, parser and RX state encodings.
package axioma_uart_io_bridge_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_BUS   = 3'd3;
   localparam logic [2:0] S_REPLY = 3'd4;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == CMD_WRITE) || (b == CMD_READ);
   endfunction

endpackage

// File: rtl/axioma_bridge_serdes.sv
// 8N1 bit engines: RX (sync, start check, mid-bit sampling) and TX.
// Ports: ser_rx/ser_tx line, rx_valid/rx_byte/frame_err, tx_start/tx_data/tx_busy.
module axioma_bridge_serdes
   import axioma_uart_io_bridge_pkg::*;
#(
   parameter int CLKS_PER_BIT = 139
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ser_rx,
   output logic       ser_tx,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err,
   output logic [1:0] rx_state,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy
);

   localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;

   logic [15:0] tx_cnt;
   logic [3:0]  tx_idx;
   logic [8:0]  tx_shift;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= RX_IDLE;
         rx_cnt    <= 16'd0;
         rx_bit    <= 3'd0;
         rx_shift  <= 8'd0;
         rx_byte   <= 8'd0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_s1     <= ser_rx;
         rx_s2     <= rx_s1;
         rx_prev   <= rx_s2;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= 16'd0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_END) begin
                  rx_cnt   <= 16'd0;
                  rx_bit   <= 3'd0;
                  // A glitch shorter than half a bit is not a start.
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= 16'd0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= 16'd0;
                  rx_state <= RX_IDLE;
                  if (rx_s2) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= rx_shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ser_tx   <= 1'b1;
         tx_busy  <= 1'b0;
         tx_cnt   <= 16'd0;
         tx_idx   <= 4'd0;
         tx_shift <= 9'h1ff;
      end else if (!tx_busy) begin
         ser_tx <= 1'b1;
         if (tx_start) begin
            // Start bit goes out on the very next cycle.
            ser_tx   <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= 16'd0;
            tx_idx   <= 4'd0;
            tx_shift <= {1'b1, tx_data};
         end
      end else if (tx_cnt == BIT_END) begin
         tx_cnt <= 16'd0;
         if (tx_idx == 4'd9) begin
            tx_busy <= 1'b0;
            ser_tx  <= 1'b1;
         end else begin
            ser_tx   <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_idx   <= tx_idx + 4'd1;
         end
      end else begin
         tx_cnt <= tx_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/axioma_uart_io_bridge.sv
// Serial command parser driving single-cycle I/O bus reads/writes.
// Ports: clk/reset_n, ser_rx/ser_tx, io_* bus, bridge_busy, debug_state.
module axioma_uart_io_bridge
   import axioma_uart_io_bridge_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 139,
   parameter logic [31:0] TIMEOUT_CLKS = 32'd1600000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ser_rx,
   output logic       ser_tx,
   output logic [5:0] io_addr,
   output logic [7:0] io_data_out,
   input  logic [7:0] io_data_in,
   output logic       io_read,
   output logic       io_write,
   output logic       bridge_busy,
   output logic [7:0] debug_state
);

   logic [2:0]  state;
   logic [2:0]  nxt;
   logic        op_read;
   logic [31:0] to_cnt;
   logic        timeout;
   logic        fe_sticky;
   logic        drop_sticky;

   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        frame_err;
   logic [1:0]  rx_state;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;

   axioma_bridge_serdes #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_serdes (
      .clk      (clk),
      .reset_n  (reset_n),
      .ser_rx   (ser_rx),
      .ser_tx   (ser_tx),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .frame_err(frame_err),
      .rx_state (rx_state),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy)
   );

   assign timeout = (to_cnt >= TIMEOUT_CLKS - 32'd1);

   // tx_start fires on the transition into S_REPLY so the start
   // bit leaves one cycle after the strobe / offending byte.
   always_comb begin
      nxt      = state;
      tx_start = 1'b0;
      tx_data  = RSP_NAK;
      case (state)
         S_IDLE: begin
            if (rx_valid) begin
               if (is_opcode(rx_byte)) begin
                  nxt = S_ADDR;
               end else begin
                  nxt      = S_REPLY;
                  tx_start = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (frame_err) begin
               nxt = S_IDLE;
            end else if (rx_valid) begin
               if (rx_byte[7:6] != 2'b00) begin
                  nxt      = S_REPLY;
                  tx_start = 1'b1;
               end else begin
                  nxt = op_read ? S_BUS : S_DATA;
               end
            end else if (timeout) begin
               nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (frame_err) begin
               nxt = S_IDLE;
            end else if (rx_valid) begin
               nxt = S_BUS;
            end else if (timeout) begin
               nxt = S_IDLE;
            end
         end
         S_BUS: begin
            nxt      = S_REPLY;
            tx_start = 1'b1;
            tx_data  = op_read ? io_data_in : RSP_ACK;
         end
         S_REPLY: begin
            if (!tx_busy) begin
               nxt = S_IDLE;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         op_read     <= 1'b0;
         io_addr     <= 6'd0;
         io_data_out <= 8'd0;
         to_cnt      <= 32'd0;
         fe_sticky   <= 1'b0;
         drop_sticky <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && rx_valid && is_opcode(rx_byte)) begin
            op_read <= (rx_byte == CMD_READ);
         end
         if (state == S_ADDR && rx_valid && rx_byte[7:6] == 2'b00) begin
            io_addr <= rx_byte[5:0];
         end
         if (state == S_DATA && rx_valid) begin
            io_data_out <= rx_byte;
         end
         if ((state == S_ADDR || state == S_DATA) && !rx_valid) begin
            to_cnt <= to_cnt + 32'd1;
         end else begin
            to_cnt <= 32'd0;
         end
         if (frame_err) begin
            fe_sticky <= 1'b1;
         end
         if (rx_valid && (state == S_BUS || state == S_REPLY)) begin
            drop_sticky <= 1'b1;
         end
      end
   end

   assign io_read     = (state == S_BUS) && op_read;
   assign io_write    = (state == S_BUS) && !op_read;
   assign bridge_busy = (state != S_IDLE);
   assign debug_state = {state, rx_state, tx_busy, fe_sticky, drop_sticky};

endmodule

// File: tb/tb_axioma_uart_io_bridge.sv
// Self-checking bench: UART host driver, TX decoder, bus model,
// and a command-level reference model of the bridge.
module tb_axioma_uart_io_bridge;

   localparam int          CPB = 16;
   localparam logic [31:0] TO  = 32'd2000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ser_rx = 1'b1;
   logic       ser_tx;
   logic [5:0] io_addr;
   logic [7:0] io_data_out;
   logic [7:0] io_data_in;
   logic       io_read;
   logic       io_write;
   logic       bridge_busy;
   logic [7:0] debug_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   axioma_uart_io_bridge #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ser_rx     (ser_rx),
      .ser_tx     (ser_tx),
      .io_addr    (io_addr),
      .io_data_out(io_data_out),
      .io_data_in (io_data_in),
      .io_read    (io_read),
      .io_write   (io_write),
      .bridge_busy(bridge_busy),
      .debug_state(debug_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus model memory plus preload port.
   logic [7:0] mem [64];
   logic [7:0] ref_mem [64];
   logic       pre_we = 1'b0;
   logic [5:0] pre_a = 6'd0;
   logic [7:0] pre_d = 8'd0;

   assign io_data_in = io_read ? mem[io_addr] : 8'h00;

   always @(posedge clk) begin
      if (io_write) mem[io_addr] <= io_data_out;
      else if (pre_we) mem[pre_a] <= pre_d;
   end

   // Bus monitor.
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         both_cnt = 0;
   int         wr_cyc = 0;
   int         rd_cyc = 0;
   logic [5:0] last_wa = 6'd0;
   logic [7:0] last_wd = 8'd0;
   logic [5:0] last_ra = 6'd0;

   initial begin
      forever begin
         @(negedge clk);
         if (io_write === 1'b1 && io_read === 1'b1) both_cnt++;
         if (io_write === 1'b1) begin
            wr_cnt++;
            wr_cyc = cyc;
            last_wa = io_addr;
            last_wd = io_data_out;
         end
         if (io_read === 1'b1) begin
            rd_cnt++;
            rd_cyc = cyc;
            last_ra = io_addr;
         end
      end
   end

   // Host-side UART receiver on ser_tx.
   logic [7:0] tx_q [$];
   int         tx_st [$];

   initial begin
      logic [7:0] db;
      int         st;
      forever begin
         @(negedge clk);
         if (reset_n && ser_tx === 1'b0) begin
            st = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               db[i] = ser_tx;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back(db);
            tx_st.push_back(st);
         end
      end
   end

   initial begin
      #700000;
      $display("FAIL watchdog: run did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop,
                            input int stop_len);
      ser_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         tick(CPB);
      end
      ser_rx = stop;
      tick(stop_len);
      ser_rx = 1'b1;
   endtask

   task automatic get_reply(output logic [7:0] b, output int st,
                            output bit ok);
      int n = 0;
      while (tx_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = (tx_q.size() != 0);
      b = 8'h00;
      st = 0;
      if (ok) begin
         b = tx_q.pop_front();
         st = tx_st.pop_front();
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bridge_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      tick(4);
   endtask

   // Command-level reference: reply byte and expected strobes.
   task automatic model(input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rep,
                        output int ew, output int er);
      ew = 0;
      er = 0;
      if (op != 8'h57 && op != 8'h52) rep = 8'h15;
      else if (a[7:6] != 2'b00) rep = 8'h15;
      else if (op == 8'h57) begin
         ew = 1;
         rep = 8'h06;
         ref_mem[a[5:0]] = d;
      end else begin
         er = 1;
         rep = ref_mem[a[5:0]];
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = 8'($urandom);
         if (i == 0) ref_mem[i] = 8'h3C;
         @(negedge clk);
         pre_a = 6'(i);
         pre_d = ref_mem[i];
         pre_we = 1'b1;
      end
      @(negedge clk);
      pre_we = 1'b0;
      checks++;
      if (ser_tx !== 1'b1 || io_read !== 1'b0 || io_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_lines tx=%b rd=%b wr=%b need 1 0 0",
                  ser_tx, io_read, io_write);
      end
      checks++;
      if (io_addr !== 6'd0 || io_data_out !== 8'd0) begin
         errors++;
         $display("FAIL reset_bus addr=%h data=%h need 0 0",
                  io_addr, io_data_out);
      end
      tick(1);
      reset_n = 1'b1;
      tick(5);
      checks++;
      if (bridge_busy !== 1'b0 || debug_state !== 8'h00) begin
         errors++;
         $display("FAIL reset_state busy=%b dbg=%h need 0 00",
                  bridge_busy, debug_state);
      end
   endtask

   task automatic test_write();
      logic [7:0] b;
      int st, w0;
      bit ok;
      w0 = wr_cnt;
      uart_send(8'h57, 1'b1, CPB);
      uart_send(8'h05, 1'b1, CPB);
      uart_send(8'hA5, 1'b1, CPB);
      get_reply(b, st, ok);
      ref_mem[5] = 8'hA5;
      wait_idle();
      checks++;
      if (!ok || b !== 8'h06) begin
         errors++;
         $display("FAIL write_reply ok=%0d got=%h need 06", ok, b);
      end
      checks++;
      if (wr_cnt - w0 != 1 || last_wa !== 6'h05 || last_wd !== 8'hA5) begin
         errors++;
         $display("FAIL write_bus n=%0d a=%h d=%h need 1 05 a5",
                  wr_cnt - w0, last_wa, last_wd);
      end
      checks++;
      if (st != wr_cyc + 1) begin
         errors++;
         $display("FAIL write_latency start=%0d need %0d", st, wr_cyc + 1);
      end
   endtask

   task automatic test_read();
      logic [7:0] b;
      int st, r0, w0;
      bit ok;
      r0 = rd_cnt;
      w0 = wr_cnt;
      uart_send(8'h52, 1'b1, CPB);
      uart_send(8'h00, 1'b1, CPB);
      get_reply(b, st, ok);
      wait_idle();
      checks++;
      if (!ok || b !== 8'h3C) begin
         errors++;
         $display("FAIL read_reply ok=%0d got=%h need 3c", ok, b);
      end
      checks++;
      if (rd_cnt - r0 != 1 || wr_cnt != w0 || last_ra !== 6'h00) begin
         errors++;
         $display("FAIL read_bus rd=%0d wr=%0d a=%h need 1 0 00",
                  rd_cnt - r0, wr_cnt - w0, last_ra);
      end
      checks++;
      if (st != rd_cyc + 1) begin
         errors++;
         $display("FAIL read_latency start=%0d need %0d", st, rd_cyc + 1);
      end
   endtask

   task automatic test_nak();
      logic [7:0] b;
      int st, r0, w0;
      bit ok;
      r0 = rd_cnt;
      w0 = wr_cnt;
      uart_send(8'h41, 1'b1, CPB);
      get_reply(b, st, ok);
      wait_idle();
      checks++;
      if (!ok || b !== 8'h15) begin
         errors++;
         $display("FAIL nak_opcode ok=%0d got=%h need 15", ok, b);
      end
      uart_send(8'h57, 1'b1, CPB);
      uart_send(8'hC6, 1'b1, CPB);
      get_reply(b, st, ok);
      wait_idle();
      checks++;
      if (!ok || b !== 8'h15) begin
         errors++;
         $display("FAIL nak_addr ok=%0d got=%h need 15", ok, b);
      end
      checks++;
      if (rd_cnt != r0 || wr_cnt != w0 || bridge_busy !== 1'b0) begin
         errors++;
         $display("FAIL nak_bus rd=%0d wr=%0d busy=%b need 0 0 0",
                  rd_cnt - r0, wr_cnt - w0, bridge_busy);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b;
      int st, r0, w0;
      bit ok;
      r0 = rd_cnt;
      w0 = wr_cnt;
      uart_send(8'h57, 1'b1, CPB);
      uart_send(8'h05, 1'b1, CPB);
      tick(2100);
      checks++;
      if (bridge_busy !== 1'b0 || tx_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_abort busy=%b replies=%0d need 0 0",
                  bridge_busy, tx_q.size());
      end
      uart_send(8'h52, 1'b1, CPB);
      uart_send(8'h05, 1'b1, CPB);
      get_reply(b, st, ok);
      wait_idle();
      checks++;
      if (!ok || b !== ref_mem[5]) begin
         errors++;
         $display("FAIL timeout_read ok=%0d got=%h need %h", ok, b,
                  ref_mem[5]);
      end
      checks++;
      if (rd_cnt - r0 != 1 || wr_cnt != w0) begin
         errors++;
         $display("FAIL timeout_bus rd=%0d wr=%0d need 1 0",
                  rd_cnt - r0, wr_cnt - w0);
      end
   endtask

   task automatic test_frame_err();
      int r0;
      r0 = rd_cnt;
      uart_send(8'h52, 1'b1, CPB);
      uart_send(8'h33, 1'b0, CPB);
      tick(300);
      checks++;
      if (tx_q.size() != 0 || rd_cnt != r0) begin
         errors++;
         $display("FAIL ferr_noreply replies=%0d rd=%0d need 0 0",
                  tx_q.size(), rd_cnt - r0);
      end
      checks++;
      if (debug_state[1] !== 1'b1 || bridge_busy !== 1'b0) begin
         errors++;
         $display("FAIL ferr_flags sticky=%b busy=%b need 1 0",
                  debug_state[1], bridge_busy);
      end
   endtask

   task automatic test_drop();
      logic [7:0] b;
      logic [5:0] a;
      int st;
      bit ok;
      a = 6'($urandom);
      checks++;
      if (debug_state[0] !== 1'b0) begin
         errors++;
         $display("FAIL drop_pre sticky=%b need 0", debug_state[0]);
      end
      uart_send(8'h52, 1'b1, CPB);
      // Short stop so the next byte lands inside the reply window.
      uart_send({2'b00, a}, 1'b1, 12);
      uart_send(8'h57, 1'b1, CPB);
      get_reply(b, st, ok);
      wait_idle();
      tick(200);
      checks++;
      if (!ok || b !== ref_mem[a]) begin
         errors++;
         $display("FAIL drop_reply ok=%0d got=%h need %h", ok, b,
                  ref_mem[a]);
      end
      checks++;
      if (debug_state[0] !== 1'b1 || bridge_busy !== 1'b0 ||
          tx_q.size() != 0) begin
         errors++;
         $display("FAIL drop_flags sticky=%b busy=%b extra=%0d need 1 0 0",
                  debug_state[0], bridge_busy, tx_q.size());
      end
   endtask

   task automatic test_random();
      logic [7:0] op, a, d, rep, b;
      int ew, er, w0, r0, st, kind;
      bit ok;
      for (int k = 0; k < 12; k++) begin
         kind = int'($urandom_range(0, 3));
         d = 8'($urandom);
         a = {2'b00, 6'($urandom)};
         op = (kind == 1) ? 8'h52 : 8'h57;
         if (kind == 2) begin
            op = 8'($urandom);
            for (int j = 0; j < 8 && is_cmd(op); j++) op = 8'($urandom);
            if (is_cmd(op)) op = 8'h00;
         end
         if (kind == 3) a[7:6] = 2'($urandom_range(1, 3));
         model(op, a, d, rep, ew, er);
         w0 = wr_cnt;
         r0 = rd_cnt;
         uart_send(op, 1'b1, CPB);
         if (is_cmd(op)) uart_send(a, 1'b1, CPB);
         if (op == 8'h57 && a[7:6] == 2'b00) uart_send(d, 1'b1, CPB);
         get_reply(b, st, ok);
         wait_idle();
         checks++;
         if (!ok || b !== rep) begin
            errors++;
            $display("FAIL rand_reply[%0d] op=%h a=%h ok=%0d got=%h need %h",
                     k, op, a, ok, b, rep);
         end
         checks++;
         if (wr_cnt - w0 != ew || rd_cnt - r0 != er ||
             (ew == 1 && (last_wa !== a[5:0] || last_wd !== d))) begin
            errors++;
            $display("FAIL rand_bus[%0d] wr=%0d rd=%0d need %0d %0d",
                     k, wr_cnt - w0, rd_cnt - r0, ew, er);
         end
      end
   endtask

   function automatic bit is_cmd(input logic [7:0] op);
      return (op == 8'h57) || (op == 8'h52);
   endfunction

   task automatic test_reset_mid();
      logic [7:0] b;
      int st, n, w0;
      bit ok;
      uart_send(8'h52, 1'b1, CPB);
      uart_send(8'h07, 1'b1, CPB);
      n = 0;
      while (ser_tx !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      tick(40);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (ser_tx !== 1'b1 || io_read !== 1'b0 || io_write !== 1'b0 ||
          bridge_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset tx=%b rd=%b wr=%b busy=%b need 1 0 0 0",
                  ser_tx, io_read, io_write, bridge_busy);
      end
      checks++;
      if (debug_state !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_dbg got=%h need 00", debug_state);
      end
      tick(5);
      reset_n = 1'b1;
      tick(200);
      tx_q.delete();
      tx_st.delete();
      w0 = wr_cnt;
      uart_send(8'h57, 1'b1, CPB);
      uart_send(8'h01, 1'b1, CPB);
      uart_send(8'h11, 1'b1, CPB);
      get_reply(b, st, ok);
      ref_mem[1] = 8'h11;
      wait_idle();
      checks++;
      if (!ok || b !== 8'h06 || wr_cnt - w0 != 1 ||
          last_wa !== 6'h01 || last_wd !== 8'h11) begin
         errors++;
         $display("FAIL post_reset ok=%0d rep=%h n=%0d a=%h d=%h",
                  ok, b, wr_cnt - w0, last_wa, last_wd);
      end
      uart_send(8'h52, 1'b1, CPB);
      uart_send(8'h01, 1'b1, CPB);
      get_reply(b, st, ok);
      wait_idle();
      checks++;
      if (!ok || b !== 8'h11) begin
         errors++;
         $display("FAIL post_reset_read ok=%0d got=%h need 11", ok, b);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nak();
      test_timeout();
      test_frame_err();
      test_drop();
      test_random();
      test_reset_mid();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL strobe_overlap cycles=%0d need 0", both_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
